// File: rtl/gauss_window_gen.sv
// Streaming 3x3 zero-padded window generator with two line buffers.
// Emits one window plus border code per pixel over valid/ready.
module gauss_window_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 8,
   parameter int IMG_H      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] line0_data0,
   output logic [DATA_WIDTH-1:0] line0_data1,
   output logic [DATA_WIDTH-1:0] line0_data2,
   output logic [DATA_WIDTH-1:0] line1_data0,
   output logic [DATA_WIDTH-1:0] line1_data1,
   output logic [DATA_WIDTH-1:0] line1_data2,
   output logic [DATA_WIDTH-1:0] line2_data0,
   output logic [DATA_WIDTH-1:0] line2_data1,
   output logic [DATA_WIDTH-1:0] line2_data2,
   output logic [3:0]            corner_type,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int FW = $clog2(IMG_W + 1);

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]            state;
   logic [XW-1:0]         ix;
   logic [YW-1:0]         iy;
   logic [XW-1:0]         cx;
   logic [YW-1:0]         cy;
   logic [FW-1:0]         fcnt;
   logic [DATA_WIDTH-1:0] lb0 [IMG_W];
   logic [DATA_WIDTH-1:0] lb1 [IMG_W];
   logic [DATA_WIDTH-1:0] raw [3][3];
   logic [DATA_WIDTH-1:0] shf [3][3];
   logic [DATA_WIDTH-1:0] tap [3][3];
   logic [DATA_WIDTH-1:0] otap [3][3];
   logic [DATA_WIDTH-1:0] col_new [3];
   logic [2:0]            row_ok;
   logic [2:0]            col_ok;
   logic [3:0]            corner_nxt;
   logic                  in_xfer;
   logic                  out_xfer;
   logic                  flush_load;
   logic                  load;
   logic                  shift;
   logic                  ix_last;
   logic                  iy_last;
   logic                  cx_last;
   logic                  cy_last;

   assign ix_last = (ix == XW'(IMG_W - 1));
   assign iy_last = (iy == YW'(IMG_H - 1));
   assign cx_last = (cx == XW'(IMG_W - 1));
   assign cy_last = (cy == YW'(IMG_H - 1));

   assign in_ready = (state == S_FILL) ||
                     ((state == S_RUN) && (!out_valid || out_ready));
   assign in_xfer    = in_valid && in_ready;
   assign out_xfer   = out_valid && out_ready;
   assign flush_load = (state == S_FLUSH) && (!out_valid || out_ready);
   assign load       = ((state == S_RUN) && in_xfer) || flush_load;
   assign shift      = in_xfer || flush_load;

   assign col_new[0] = lb0[ix];
   assign col_new[1] = lb1[ix];
   assign col_new[2] = (state == S_FLUSH) ? '0 : in_data;

   assign row_ok = {!cy_last, 1'b1, cy != '0};
   assign col_ok = {!cx_last, 1'b1, cx != '0};

   // Taps are masked by centre coordinates, never by buffer contents
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         shf[r][0] = raw[r][1];
         shf[r][1] = raw[r][2];
         shf[r][2] = col_new[r];
         for (int c = 0; c < 3; c++)
            tap[r][c] = (row_ok[r] && col_ok[c]) ? shf[r][c] : '0;
      end
   end

   always_comb begin
      corner_nxt = 4'd8;
      if      (!row_ok[0] && !col_ok[0]) corner_nxt = 4'd1;
      else if (!row_ok[0] && !col_ok[2]) corner_nxt = 4'd2;
      else if (!row_ok[2] && !col_ok[0]) corner_nxt = 4'd5;
      else if (!row_ok[2] && !col_ok[2]) corner_nxt = 4'd6;
      else if (!col_ok[0])               corner_nxt = 4'd3;
      else if (!col_ok[2])               corner_nxt = 4'd4;
      else if (!row_ok[2])               corner_nxt = 4'd7;
   end

   always_ff @(posedge clk) begin
      if (shift) begin
         lb0[ix] <= lb1[ix];
         lb1[ix] <= col_new[2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FILL;
         ix    <= '0;
         iy    <= '0;
         fcnt  <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               raw[r][c] <= '0;
      end else begin
         if (shift) begin
            ix <= ix_last ? '0 : ix + 1'b1;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  raw[r][c] <= shf[r][c];
         end
         if (in_xfer && ix_last)
            iy <= iy_last ? '0 : iy + 1'b1;
         case (state)
            S_FILL: begin
               if (in_xfer && ix == '0 && iy == YW'(1))
                  state <= S_RUN;
            end
            S_RUN: begin
               if (in_xfer && ix_last && iy_last) begin
                  state <= S_FLUSH;
                  fcnt  <= '0;
               end
            end
            S_FLUSH: begin
               if (flush_load) begin
                  fcnt <= fcnt + 1'b1;
                  if (fcnt == FW'(IMG_W)) begin
                     state <= S_FILL;
                     ix    <= '0;
                     iy    <= '0;
                  end
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         corner_type <= '0;
         cx          <= '0;
         cy          <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               otap[r][c] <= '0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_last    <= cx_last && cy_last;
         corner_type <= corner_nxt;
         cx          <= cx_last ? '0 : cx + 1'b1;
         if (cx_last)
            cy <= cy_last ? '0 : cy + 1'b1;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               otap[r][c] <= tap[r][c];
      end else if (out_xfer) begin
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         corner_type <= '0;
      end
   end

   assign line0_data0 = otap[0][0];
   assign line0_data1 = otap[0][1];
   assign line0_data2 = otap[0][2];
   assign line1_data0 = otap[1][0];
   assign line1_data1 = otap[1][1];
   assign line1_data2 = otap[1][2];
   assign line2_data0 = otap[2][0];
   assign line2_data1 = otap[2][1];
   assign line2_data2 = otap[2][2];

endmodule

// File: tb/tb_gauss_window_gen.sv
// Directed bench for gauss_window_gen on a 4x3 frame, pixel k = k+1.
// Windows are checked against hand constants and a coordinate model.
module tb_gauss_window_gen;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] l00, l01, l02, l10, l11, l12, l20, l21, l22;
   logic [3:0] corner_type;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   logic [7:0] tp [9];

   int checks;
   int errors;
   int win [N][9];
   int wcorner [N];
   int wlast [N];
   int nwin;
   int flush_xfers;
   int last_ready;

   gauss_window_gen #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .line0_data0(l00),
      .line0_data1(l01),
      .line0_data2(l02),
      .line1_data0(l10),
      .line1_data1(l11),
      .line1_data2(l12),
      .line2_data0(l20),
      .line2_data1(l21),
      .line2_data2(l22),
      .corner_type(corner_type),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last)
   );

   assign tp[0] = l00;
   assign tp[1] = l01;
   assign tp[2] = l02;
   assign tp[3] = l10;
   assign tp[4] = l11;
   assign tp[5] = l12;
   assign tp[6] = l20;
   assign tp[7] = l21;
   assign tp[8] = l22;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_tap(input int n, input int i);
      int x;
      int y;
      x = (n % W) - 1 + (i % 3);
      y = (n / W) - 1 + (i / 3);
      if (x < 0 || x > W - 1 || y < 0 || y > H - 1) return 0;
      return y * W + x + 1;
   endfunction

   function automatic int model_corner(input int n);
      int x;
      int y;
      x = n % W;
      y = n / W;
      if (y == 0 && x == 0) return 1;
      if (y == 0 && x == W - 1) return 2;
      if (y == H - 1 && x == 0) return 5;
      if (y == H - 1 && x == W - 1) return 6;
      if (x == 0) return 3;
      if (x == W - 1) return 4;
      if (y == H - 1) return 7;
      return 8;
   endfunction

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_frame(input int bp_at, input int bp_len);
      int  k;
      int  cyc;
      bit  done;
      bit  holding;
      logic [7:0] held [9];
      k = 0;
      nwin = 0;
      done = 0;
      holding = 0;
      flush_xfers = 0;
      last_ready = 0;
      for (cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= bp_at && cyc < bp_at + bp_len);
         in_valid  = (k < N);
         in_data   = 8'(k + 1);
         #1;
         if (!out_ready && out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_in_ready got=%0b want=0", in_ready);
            end
            if (holding) begin
               for (int i = 0; i < 9; i++) begin
                  checks++;
                  if (tp[i] !== held[i]) begin
                     errors++;
                     $display("FAIL bp_hold tap%0d got=%0d want=%0d",
                              i, tp[i], held[i]);
                  end
               end
            end
            held = tp;
            holding = 1;
         end else begin
            holding = 0;
         end
         if (k == N && !(out_valid && out_last)) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL flush_in_ready got=%0b want=0", in_ready);
            end
         end
         if (out_valid && out_ready) begin
            if (k == N) flush_xfers++;
            if (nwin < N) begin
               for (int i = 0; i < 9; i++) begin
                  win[nwin][i] = int'(tp[i]);
                  checks++;
                  if (tp[i] !== 8'(model_tap(nwin, i))) begin
                     errors++;
                     $display("FAIL win%0d_tap%0d got=%0d want=%0d",
                              nwin, i, tp[i], model_tap(nwin, i));
                  end
               end
               wcorner[nwin] = int'(corner_type);
               wlast[nwin]   = int'(out_last);
               checks++;
               if (corner_type !== 4'(model_corner(nwin))) begin
                  errors++;
                  $display("FAIL win%0d_corner got=%0d want=%0d",
                           nwin, corner_type, model_corner(nwin));
               end
               checks++;
               if (out_last !== (nwin == N - 1)) begin
                  errors++;
                  $display("FAIL win%0d_last got=%0b want=%0b",
                           nwin, out_last, nwin == N - 1);
               end
            end
            if (out_last) begin
               done = 1;
               last_ready = int'(in_ready);
            end
            nwin++;
         end
         if (in_valid && in_ready) k++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_timeout got=%0d windows want=%0d", nwin, N);
      end
      checks++;
      if (nwin != N) begin
         errors++;
         $display("FAIL frame_count got=%0d want=%0d", nwin, N);
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom_range(0, 255));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (out_valid !== 1'b0 || corner_type !== 4'd0 ||
             in_ready !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%0b/%0d/%0b/%0b want=0/0/1/0",
                     out_valid, corner_type, in_ready, out_last);
         end
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (tp[i] !== 8'd0) begin
               errors++;
               $display("FAIL reset_tap%0d got=%0d want=0", i, tp[i]);
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
   endtask

   task automatic test_start();
      int e [9];
      e = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
      run_frame(1000, 0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (win[0][i] != e[i]) begin
            errors++;
            $display("FAIL start_tap%0d got=%0d want=%0d", i, win[0][i], e[i]);
         end
      end
      checks++;
      if (wcorner[0] != 1) begin
         errors++;
         $display("FAIL start_corner got=%0d want=1", wcorner[0]);
      end
   endtask

   task automatic test_interior();
      int e5 [9];
      int e7 [9];
      e5 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      e7 = '{3, 4, 0, 7, 8, 0, 11, 12, 0};
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (win[5][i] != e5[i]) begin
            errors++;
            $display("FAIL centre6_tap%0d got=%0d want=%0d", i, win[5][i], e5[i]);
         end
         checks++;
         if (win[7][i] != e7[i]) begin
            errors++;
            $display("FAIL centre8_tap%0d got=%0d want=%0d", i, win[7][i], e7[i]);
         end
      end
      checks++;
      if (wcorner[5] != 8 || wcorner[7] != 4) begin
         errors++;
         $display("FAIL interior_corner got=%0d,%0d want=8,4",
                  wcorner[5], wcorner[7]);
      end
   endtask

   task automatic test_flush();
      int e [9];
      e = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (win[N-1][i] != e[i]) begin
            errors++;
            $display("FAIL last_tap%0d got=%0d want=%0d", i, win[N-1][i], e[i]);
         end
      end
      checks++;
      if (wcorner[N-1] != 6 || wlast[N-1] != 1) begin
         errors++;
         $display("FAIL last_flags got=%0d/%0d want=6/1",
                  wcorner[N-1], wlast[N-1]);
      end
      checks++;
      if (flush_xfers != W + 2) begin
         errors++;
         $display("FAIL flush_windows got=%0d want=%0d", flush_xfers, W + 2);
      end
      checks++;
      if (last_ready != 1) begin
         errors++;
         $display("FAIL fill_after_flush got=%0d want=1", last_ready);
      end
   endtask

   task automatic test_back_to_back();
      int e [9];
      e = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
      run_frame(1000, 0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (win[0][i] != e[i]) begin
            errors++;
            $display("FAIL b2b_tap%0d got=%0d want=%0d", i, win[0][i], e[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      run_frame(8, 5);
      run_frame(13, 3);
   endtask

   task automatic test_reset_mid();
      int k;
      int e [9];
      e = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
      k = 0;
      for (int cyc = 0; cyc < 50 && k < 7; cyc++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_data   = 8'(k + 1);
         #1;
         if (in_ready) k++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || corner_type !== 4'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset got=%0b/%0d/%0b want=0/0/1",
                  out_valid, corner_type, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(1000, 0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (win[0][i] != e[i]) begin
            errors++;
            $display("FAIL midreset_tap%0d got=%0d want=%0d", i, win[0][i], e[i]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      test_reset();
      do_reset();
      test_start();
      test_interior();
      test_flush();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
